// File: rtl/d5m_pkg.sv
// Shared types for the D5M Bayer capture block: capture FSM states, Bayer
// phase of the current pixel, and RGB24 output packing.
package d5m_pkg;

    localparam int RGB_W = 24;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SYNC    = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    // Phase is {row parity, column parity}: even rows carry G1,R and odd
    // rows carry B,G2.
    typedef enum logic [1:0] {
        PH_G1 = 2'b00,
        PH_R  = 2'b01,
        PH_B  = 2'b10,
        PH_G2 = 2'b11
    } phase_t;

    function automatic logic [RGB_W-1:0] pack_rgb24(input logic [7:0] r,
                                                    input logic [7:0] g,
                                                    input logic [7:0] b);
        return {r, g, b};
    endfunction

endpackage

// File: rtl/d5m_bayer_capture_if.sv
// Sensor-side and RGB-side signal bundle of the D5M Bayer capture block.
// master = sensor/consumer side, slave = capture block side.
interface d5m_bayer_capture_if
    import d5m_pkg::*;
#(
    parameter int DATA_W = 12
);
    logic              fval;
    logic              lval;
    logic [DATA_W-1:0] pix;
    logic              active;
    logic [RGB_W-1:0]  rgb;
    logic              line_end;
    logic              frame_end;
    logic              overflow;

    modport master (
        output fval, lval, pix,
        input  active, rgb, line_end, frame_end, overflow
    );

    modport slave (
        input  fval, lval, pix,
        output active, rgb, line_end, frame_end, overflow
    );
endinterface

// File: rtl/d5m_line_buffer.sv
// Simple dual-port line store: one write port, one registered read port.
// Contents are deliberately not reset.
module d5m_line_buffer #(
    parameter  int DEPTH  = 1296,
    parameter  int WIDTH  = 24,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Registered read port: data appears the cycle after rd_en.
    always_ff @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/d5m_bayer_capture.sv
// D5M Bayer capture: waits for a fresh frame, stores each even-row {G1,R}
// pair, and on the odd row combines it with {B,G2} into one RGB24 pixel per
// 2x2 quad. Output follows the G2 sample by exactly 2 cycles.
// Optional: define D5M_CAPTURE_STATS_EN to add frame/line counters.
module d5m_bayer_capture
    import d5m_pkg::*;
#(
    parameter int DATA_W   = 12,
    parameter int MAX_LINE = 2592
) (
    input  logic              ul1Clock,
    input  logic              ul1Reset,
    input  logic              ul1Enable,
    input  logic              ul1Fval,
    input  logic              ul1Lval,
    input  logic [DATA_W-1:0] ulPixData,
    output logic              ul1Active,
    output logic [RGB_W-1:0]  ul24Rgb24Data,
    output logic              ul1LineEnd,
    output logic              ul1FrameEnd,
    output logic              ul1Overflow
`ifdef D5M_CAPTURE_STATS_EN
    ,
    output logic [15:0]       ul16FrameCount,
    output logic [15:0]       ul16LineCount
`endif
);
    localparam int DEPTH  = MAX_LINE / 2;
    localparam int COL_W  = $clog2(MAX_LINE + 1);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PAIR_W = 2 * DATA_W;

    function automatic logic [7:0] top8(input logic [DATA_W-1:0] v);
        return v[DATA_W-1 -: 8];
    endfunction

    // Average keeps the carry bit, so the halved sum is bits [DATA_W:1].
    function automatic logic [7:0] g_avg(input logic [DATA_W-1:0] a,
                                         input logic [DATA_W-1:0] b);
        logic [DATA_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[DATA_W -: 8];
    endfunction

    state_t            state;
    logic              fval_d, lv_d;
    logic [COL_W-1:0]  col;
    logic              row_odd;
    logic [COL_W-1:0]  even_pairs;
    logic [DATA_W-1:0] g1_hold, b_hold;
    logic [DATA_W-1:0] g2_p1, b_p1;
    logic              vld_p1, lend_p1, vld_p2, lend_p2;
    logic [RGB_W-1:0]  rgb_p2;
    logic [PAIR_W-1:0] rd_data;

    // Line valid only counts inside frame valid.
    logic lv, fval_rise, fval_fall, lv_fall, cap, acc, start, wr_en, rd_en;
    logic [COL_W-1:0] pair_idx;
    phase_t phase;

    assign lv        = ul1Lval & ul1Fval;
    assign fval_rise = ul1Fval & ~fval_d;
    assign fval_fall = ~ul1Fval & fval_d;
    assign lv_fall   = lv_d & ~lv;
    assign cap       = (state == ST_CAPTURE);
    assign start     = (state == ST_SYNC) & fval_rise;
    assign acc       = cap & lv & (col < COL_W'(MAX_LINE));
    assign phase     = phase_t'({row_odd, col[0]});
    assign pair_idx  = col >> 1;
    assign wr_en     = acc & (phase == PH_R);
    assign rd_en     = acc & (phase == PH_G2) & (pair_idx < even_pairs);

    d5m_line_buffer #(.DEPTH(DEPTH), .WIDTH(PAIR_W)) u_line_buffer (
        .clk     (ul1Clock),
        .wr_en   (wr_en),
        .wr_addr (ADDR_W'(pair_idx)),
        .wr_data ({g1_hold, ulPixData}),
        .rd_en   (rd_en),
        .rd_addr (ADDR_W'(pair_idx)),
        .rd_data (rd_data)
    );

    // Capture FSM with registered frame-end pulse and sticky overflow.
    always_ff @(posedge ul1Clock or posedge ul1Reset) begin
        if (ul1Reset) begin
            state       <= ST_IDLE;
            ul1FrameEnd <= 1'b0;
            ul1Overflow <= 1'b0;
        end else begin
            ul1FrameEnd <= 1'b0;
            case (state)
                ST_IDLE: if (ul1Enable) state <= ST_SYNC;
                ST_SYNC: if (fval_rise) begin
                    state       <= ST_CAPTURE;
                    ul1Overflow <= 1'b0;
                end
                ST_CAPTURE: begin
                    if (lv && col == COL_W'(MAX_LINE)) ul1Overflow <= 1'b1;
                    if (fval_fall) begin
                        ul1FrameEnd <= 1'b1;
                        state       <= ul1Enable ? ST_SYNC : ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Edge detectors, column/row position and even-row pair count.
    // fval_d resets high so a frame already running at reset release is
    // never mistaken for a new frame start.
    always_ff @(posedge ul1Clock or posedge ul1Reset) begin
        if (ul1Reset) begin
            fval_d     <= 1'b1;
            lv_d       <= 1'b0;
            col        <= '0;
            row_odd    <= 1'b0;
            even_pairs <= '0;
        end else begin
            fval_d <= ul1Fval;
            lv_d   <= lv;
            if (!cap || !lv)                  col <= '0;
            else if (col < COL_W'(MAX_LINE))  col <= col + COL_W'(1);
            if (start)                        row_odd <= 1'b0;
            else if (cap && lv_fall)          row_odd <= ~row_odd;
            if (start || (cap && lv_fall && row_odd)) even_pairs <= '0;
            else if (wr_en)                   even_pairs <= pair_idx + COL_W'(1);
        end
    end

    // Pixel holding and stage p1/p2 data (no reset on data).
    always_ff @(posedge ul1Clock) begin
        if (acc && phase == PH_G1) g1_hold <= ulPixData;
        if (acc && phase == PH_B)  b_hold  <= ulPixData;
        // p0 -> p1: G2 sampled, stored pair being read
        if (rd_en) begin
            g2_p1 <= ulPixData;
            b_p1  <= b_hold;
        end
        // p1 -> p2: combine stored {G1,R} with {B,G2}
        rgb_p2 <= pack_rgb24(top8(rd_data[DATA_W-1:0]),
                             g_avg(rd_data[PAIR_W-1:DATA_W], g2_p1),
                             top8(b_p1));
    end

    // Valid/line-end pipeline and registered outputs.
    always_ff @(posedge ul1Clock or posedge ul1Reset) begin
        if (ul1Reset) begin
            vld_p1        <= 1'b0;
            lend_p1       <= 1'b0;
            vld_p2        <= 1'b0;
            lend_p2       <= 1'b0;
            ul1Active     <= 1'b0;
            ul1LineEnd    <= 1'b0;
            ul24Rgb24Data <= '0;
        end else begin
            // p0 -> p1: a pair at the last storable column ends the line
            vld_p1        <= rd_en;
            lend_p1       <= (col == COL_W'(MAX_LINE - 1));
            // p1 -> p2: line valid dropping right after G2 ends the line
            vld_p2        <= vld_p1;
            lend_p2       <= lend_p1 | lv_fall;
            // p2 -> out: a trailing odd pixel delays the drop by one cycle
            ul1Active     <= vld_p2;
            ul1LineEnd    <= vld_p2 & (lend_p2 | lv_fall);
            ul24Rgb24Data <= vld_p2 ? rgb_p2 : '0;
        end
    end

`ifdef D5M_CAPTURE_STATS_EN
    // Captured-frame and current-frame row counters.
    always_ff @(posedge ul1Clock or posedge ul1Reset) begin
        if (ul1Reset) begin
            ul16FrameCount <= '0;
            ul16LineCount  <= '0;
        end else begin
            if (cap && fval_fall) ul16FrameCount <= ul16FrameCount + 16'd1;
            if (start)            ul16LineCount  <= '0;
            else if (cap && lv_fall) ul16LineCount <= ul16LineCount + 16'd1;
        end
    end
`endif

endmodule

// File: doc/d5m_bayer_capture.md
D5M_BAYER_CAPTURE -- requirements
Module: d5m_bayer_capture

Interface
REQ-001 SHALL have parameter DATA_W, default 12, sensor pixel width (8..12).
REQ-002 SHALL have parameter MAX_LINE, default 2592, maximum sensor pixels per line; even, at least 4.
REQ-003 SHALL have port ul1Clock, in, 1, pixel clock; the sensor is sampled and all logic runs on the rising edge.
REQ-004 SHALL have port ul1Reset, in, 1, reset (asynchronous, active-high).
REQ-005 SHALL have port ul1Enable, in, 1, capture request, level-sensitive.
REQ-006 SHALL have port ul1Fval, in, 1, sensor frame valid.
REQ-007 SHALL have port ul1Lval, in, 1, sensor line valid.
REQ-008 SHALL have port ulPixData, in, DATA_W, sensor Bayer pixel.
REQ-009 SHALL have port ul1Active, out, 1, qualifies ul24Rgb24Data.
REQ-010 SHALL have port ul24Rgb24Data, out, 24, {R,G,B} 8 bits each.
REQ-011 SHALL have port ul1LineEnd, out, 1, marks the last output pixel of a line.
REQ-012 SHALL have port ul1FrameEnd, out, 1, one-cycle pulse after a captured frame completes.
REQ-013 SHALL have port ul1Overflow, out, 1, sticky flag for a line longer than MAX_LINE.

Function
REQ-014 SHALL implement states IDLE, SYNC and CAPTURE.
- IDLE -> SYNC when ul1Enable=1.
- SYNC -> CAPTURE on the first rising edge of ul1Fval seen while in SYNC; a frame already in progress is skipped.
- CAPTURE -> IDLE on the falling edge of ul1Fval when ul1Enable=0; otherwise CAPTURE -> SYNC.
REQ-015 SHALL pulse ul1FrameEnd for 1 cycle on the ul1Fval falling edge that ends CAPTURE.
REQ-016 SHALL treat the Bayer pattern as: row 0 of the frame = G1,R,G1,R...; row 1 = B,G2,B,G2...; the pattern repeats every 2 rows.
REQ-017 SHALL count rows in CAPTURE on each ul1Lval falling edge; row parity SHALL reset to 0 on the ul1Fval rising edge.
REQ-018 SHALL, on even rows, write each {G1,R} pixel pair into a line buffer (depth MAX_LINE/2, width 2*DATA_W) at pair index.
REQ-019 SHALL, on odd rows, read back the stored pair at the matching pair index when the second pixel (G2) of the pair arrives.
- R = R[DATA_W-1 -: 8].
- B = B[DATA_W-1 -: 8].
- G = (G1+G2) computed at DATA_W+1 bits, shifted right 1, then top 8 bits taken.
REQ-020 SHALL assert ul1Active with the result exactly 2 cycles after the G2 sample cycle; no output is produced on even rows.
REQ-021 SHALL assert ul1LineEnd with the output pixel generated from the final complete pair before ul1Lval falls.
REQ-022 SHALL discard a trailing unpaired pixel on odd-length lines.
REQ-023 SHALL drop pixels beyond MAX_LINE in a line, and set ul1Overflow.
REQ-024 SHALL clear ul1Overflow on the next ul1Fval rising edge accepted in SYNC.
REQ-025 SHALL produce no output when an odd row arrives without a preceding even row.
REQ-026 SHALL ignore ul1Lval outside ul1Fval, and ignore ul1Lval while in IDLE or SYNC.

Reset
REQ-027 SHALL, while ul1Reset=1, force the state to IDLE and clear all counters.
REQ-028 SHALL hold ul1Active, ul24Rgb24Data, ul1LineEnd, ul1FrameEnd and ul1Overflow at 0 during reset.
REQ-029 SHALL leave the line buffer contents uncleared on reset.
REQ-030 SHALL, after reset is removed mid-frame, wait in SYNC for a new ul1Fval rising edge before capturing.

Configuration
REQ-031 SHALL, with D5M_CAPTURE_STATS_EN defined, add outputs ul16FrameCount and ul16LineCount.
- ul16FrameCount: captured frames, increments on ul1FrameEnd, wraps at 65535->0.
- ul16LineCount: rows of the current frame; reset on the ul1Fval rising edge; holds its value after the frame ends.
- Both are 0 on reset.
REQ-032 SHALL, without D5M_CAPTURE_STATS_EN, have neither port nor the counter logic.

Structure
REQ-033 SHALL place the state enumeration, the Bayer phase enumeration and the RGB24 packing function in the shared package d5m_pkg.
REQ-034 SHALL implement the line buffer as sub-module d5m_line_buffer: simple dual-port, 1 write port and 1 registered read port, parameterised by depth and width.

Verification
REQ-035 SHALL cover: ul1Enable=1, 4x4 frame, G1=0x800, R=0xFFF, B=0x000, G2=0x400 -> 2x2 output pixels, each 0xFF6000, 2 cycles after each G2; ul1LineEnd on the 2nd pixel of the line.
REQ-036 SHALL cover: ul1Enable raised mid-frame -> no output for that frame; capture starts at the next ul1Fval rise.
REQ-037 SHALL cover: MAX_LINE=8, line of 10 pixels -> 4 outputs, ul1Overflow=1 until the next frame start.
REQ-038 SHALL cover: line of 5 pixels -> 2 outputs; the 5th pixel is ignored.
REQ-039 SHALL cover: ul1Reset pulsed during row 1 -> outputs go to 0 immediately; no output until a new ul1Fval rise.
REQ-040 SHALL cover: with D5M_CAPTURE_STATS_EN, 3 frames of 6 rows -> ul16FrameCount=3, ul16LineCount=6.
